reg_fifo_write_arbiter: RTL and testbench
=========================================

Name: reg_fifo_write_arbiter

Overview:
- Shares the write side of the 32-bit register-crossing dual-clock FIFO among NUM_REQ register-update sources.
- That FIFO has only a valid on its sink, no ready, so it drops or overflows silently when pushed past its usable depth.
- This block arbitrates round-robin between requesters and gates every push with a credit counter, so the FIFO is never written beyond CREDITS outstanding entries.
- Credits come back as pulses from the read side, already synchronized into this clock domain by the caller.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- DATA_WIDTH, 32: payload width; must equal the FIFO width.
- CREDITS, 5: maximum outstanding FIFO entries (FIFO depth 8 minus 3 reserve).
- CNT_WIDTH, 3: width of the credit counter; must satisfy 2^CNT_WIDTH > CREDITS.

Ports:
- clk, in, 1: the single clock (FIFO write clock).
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, NUM_REQ: per-requester valid.
- req_data, in, NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready, out, NUM_REQ: one-hot grant, combinational.
- enable, in, 1: when 0, no new grants are issued.
- credit_return, in, 1: single-cycle pulse; one FIFO entry has been drained.
- fifo_data, out, DATA_WIDTH: drives the FIFO sink data.
- fifo_valid, out, 1: drives the FIFO sink valid.
- credit_cnt, out, CNT_WIDTH: credits currently available.
- last_grant_id, out, 4: index of the most recent grant.
- credit_err, out, 1: sticky flag; a credit was returned while the counter was already full.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - credit_cnt=CREDITS, fifo_valid=0, fifo_data=0, credit_err=0.
  - Round-robin pointer rr_ptr=NUM_REQ-1, so requester 0 has first priority after reset; last_grant_id=0.
  - req_ready is forced to 0 while rst=1.
- Grant condition:
  - can_grant = enable && (credit_cnt != 0) && (|req_valid).
  - The winner is the first i with req_valid[i]=1, searching from (rr_ptr+1) mod NUM_REQ upward and wrapping.
  - req_ready = one-hot(winner) when can_grant, else 0.
  - A transfer occurs when req_valid[i] && req_ready[i].
- Requesters:
  - Must hold req_valid and req_data stable until ready.
  - Ready may be asserted in the same cycle valid first rises.
  - Ready never depends on the requester's own ready; no combinational loop.
- Output pipeline, 1-cycle latency:
  - On transfer: fifo_data <= winner's data, fifo_valid <= 1, rr_ptr <= winner, last_grant_id <= winner.
  - Otherwise: fifo_valid <= 0 and fifo_data holds its previous value.
  - Back-to-back grants produce fifo_valid high on consecutive cycles; peak throughput is one word per cycle.
- Credit arithmetic:
  - push = transfer this cycle; ret = credit_return.
  - push and not ret: credit_cnt - 1. ret and not push: credit_cnt + 1. Both or neither: unchanged.
  - The counter never goes below 0, because the grant requires credit_cnt != 0.
  - If ret arrives with credit_cnt == CREDITS and no push: the counter saturates at CREDITS and credit_err is set to 1, remaining 1 until rst.
  - A grant at credit_cnt=1 with a simultaneous ret leaves credit_cnt=1.
- Fairness:
  - A requester that keeps valid asserted is granted at least once every NUM_REQ grants.
  - rr_ptr does not advance on cycles without a grant.
- Enable:
  - Dropping enable blocks new grants from the same cycle.
  - An already-registered fifo_valid still completes on the following edge.
  - Credits continue to be accounted while enable=0.
- Reset mid-operation:
  - Any word registered in fifo_valid is discarded (fifo_valid=0 after the reset edge).
  - Credits return to CREDITS. The caller must reset the FIFO at the same time.
  - Requesters see ready=0 for the whole reset period.

Test Plan:
- Single requester: req_valid=0001, data=0xDEADBEEF, 1 cycle → req_ready=0001 in the same cycle; next cycle fifo_valid=1, fifo_data=0xDEADBEEF, credit_cnt=4, last_grant_id=0.
- All four valid continuously, with credit_return pulsed every cycle from cycle 2 → grant order 0,1,2,3,0,1,...; each requester gets exactly 2 grants in 8 consecutive grants.
- Credit exhaustion: requester 2 valid continuously, no returns → exactly 5 fifo_valid pulses, then req_ready=0 and credit_cnt=0. One credit_return pulse → exactly one more grant, then credit_cnt=0 again.
- Simultaneous push and return at credit_cnt=1 → credit_cnt stays 1 and a further grant issues next cycle. A credit_return at credit_cnt=5 with no push → credit_cnt stays 5 and credit_err=1 until rst.
- enable=0 with all valid for 10 cycles → req_ready=0, fifo_valid=0, rr_ptr unchanged. enable=1 → grant goes to (last_grant_id+1) mod 4.
- rst asserted for 1 cycle mid-burst, with credit_cnt=2 and fifo_valid=1 → after the edge fifo_valid=0, credit_cnt=5, credit_err=0, and the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/reg_fifo_write_arbiter.sv
// Round-robin, credit-gated write arbiter for the register-crossing FIFO.
// Several register-update sources share the FIFO write port. The FIFO sink has
// no back-pressure, so every push spends a credit. Credits come back as pulses
// from the read side, already synchronized into this clock domain.
//
// Handshake (per requester i): a word moves when req_valid[i] && req_ready[i]
// are both high at a rising clk edge. req_valid/req_data must stay stable until
// ready is seen. req_ready may rise in the same cycle valid first rises, and it
// never depends on any req_ready, so there is no combinational loop.
module reg_fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CREDITS    = 5,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          enable,
    input  logic                          credit_return,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_valid,
    output logic [CNT_WIDTH-1:0]          credit_cnt,
    output logic [3:0]                    last_grant_id,
    output logic                          credit_err
);

    // Index of the most recent winner; the search starts just above it.
    logic [3:0]            rr_ptr;
    logic                  hi_found;
    logic [3:0]            hi_idx;
    logic                  lo_found;
    logic [3:0]            lo_idx;
    logic [3:0]            win_idx;
    logic                  can_grant;
    logic                  push;
    logic [NUM_REQ-1:0]    grant_vec;
    logic [DATA_WIDTH-1:0] win_data;

    // Round-robin search: lowest valid index above rr_ptr, else wrap to the
    // lowest valid index at or below rr_ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (4'(i) > rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = 4'(i);
            end
            if (req_valid[i] && (4'(i) <= rr_ptr)) begin
                lo_found = 1'b1;
                lo_idx   = 4'(i);
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
    end

    // Grant only with a credit in hand, while enabled and out of reset.
    always_comb begin
        can_grant = enable && (credit_cnt != '0) && (hi_found || lo_found) && !rst;
        grant_vec = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_vec[i] = can_grant && (win_idx == 4'(i));
            if (grant_vec[i]) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        push      = |(grant_vec & req_valid);
        req_ready = grant_vec;
    end

    // Output register, round-robin pointer and credit accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_valid    <= 1'b0;
            fifo_data     <= '0;
            credit_cnt    <= CNT_WIDTH'(CREDITS);
            credit_err    <= 1'b0;
            rr_ptr        <= 4'(NUM_REQ - 1);
            last_grant_id <= '0;
        end else begin
            fifo_valid <= push;
            if (push) begin
                fifo_data     <= win_data;
                rr_ptr        <= win_idx;
                last_grant_id <= win_idx;
            end
            if (push && !credit_return) begin
                credit_cnt <= credit_cnt - CNT_WIDTH'(1);
            end else if (credit_return && !push) begin
                if (credit_cnt == CNT_WIDTH'(CREDITS)) begin
                    // Over-return: saturate and flag until the next reset.
                    credit_err <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_fifo_write_arbiter.sv
// Self-checking bench for reg_fifo_write_arbiter (NUM_REQ=4, 32-bit data, 5 credits).
module tb_reg_fifo_write_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         enable;
    logic         credit_return;
    logic [31:0]  fifo_data;
    logic         fifo_valid;
    logic [2:0]   credit_cnt;
    logic [3:0]   last_grant_id;
    logic         credit_err;

    int n_pass;
    int n_total;

    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h11111111;
    localparam logic [31:0] D2 = 32'h22222222;
    localparam logic [31:0] D3 = 32'h33333333;

    reg_fifo_write_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(32), .CREDITS(5), .CNT_WIDTH(3)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .enable(enable), .credit_return(credit_return),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .credit_cnt(credit_cnt),
        .last_grant_id(last_grant_id), .credit_err(credit_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        ret;
        logic [3:0]  valid;
        logic [3:0]  exp_ready;
        logic        exp_fv;
        logic [31:0] exp_fd;
        logic [2:0]  exp_cnt;
        logic [3:0]  exp_last;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // advance one edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic c, input logic [3:0] v);
        rst           = r;
        enable        = e;
        credit_return = c;
        req_valid     = v;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 4'b0000);
        step();
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
    endtask

    initial begin
        int pulses;
        int cnt_per[4];
        int w;

        n_pass   = 0;
        n_total  = 0;
        req_data = {D3, D2, D1, D0};

        //           rst  en   ret  valid    ready    fv   fd  cnt   last  err
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 32'h0, 3'd5, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, D0, 3'd4, 4'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, D0, 3'd4, 4'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, D0, 3'd5, 4'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, D0, 3'd5, 4'd0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, D0, 3'd5, 4'd0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0, 3'd5, 4'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'b1010, 4'b0010, 1'b1, D1, 3'd4, 4'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, D1, 3'd4, 4'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b1, D2, 3'd3, 4'd2, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b1000, 1'b1, D3, 3'd3, 4'd3, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, D0, 3'd2, 4'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, D0, 3'd2, 4'd0, 1'b0};

        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        step();
        step();

        // table-driven vectors
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].ret, vecs[i].valid);
            check($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            step();
            check($sformatf("v%0d fifo_valid", i), 32'(fifo_valid), 32'(vecs[i].exp_fv));
            check($sformatf("v%0d fifo_data", i), fifo_data, vecs[i].exp_fd);
            check($sformatf("v%0d credit_cnt", i), 32'(credit_cnt), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d last_grant_id", i), 32'(last_grant_id), 32'(vecs[i].exp_last));
            check($sformatf("v%0d credit_err", i), 32'(credit_err), 32'(vecs[i].exp_err));
        end

        // fairness: all valid, returns every cycle from cycle 2
        do_reset();
        for (int k = 0; k < 4; k++) cnt_per[k] = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, (k >= 2), 4'b1111);
            check($sformatf("rr order %0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            w = -1;
            for (int j = 0; j < 4; j++) if (req_ready[j]) w = j;
            if (w >= 0) cnt_per[w]++;
            step();
            check($sformatf("rr data %0d", k), fifo_data, req_data[(k % 4)*32 +: 32]);
        end
        for (int j = 0; j < 4; j++) check($sformatf("rr count %0d", j), 32'(cnt_per[j]), 32'd2);
        check("rr credit_cnt", 32'(credit_cnt), 32'd3);

        // credit exhaustion with requester 2
        do_reset();
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b0100);
            step();
            if (fifo_valid) pulses++;
        end
        check("exhaust pulses", 32'(pulses), 32'd5);
        check("exhaust ready", 32'(req_ready), 32'd0);
        check("exhaust credit_cnt", 32'(credit_cnt), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 4'b0100);
        check("ret at zero ready", 32'(req_ready), 32'd0);
        step();
        check("one credit back", 32'(credit_cnt), 32'd1);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b0100);
            step();
            if (fifo_valid) pulses++;
        end
        check("one more grant", 32'(pulses), 32'd1);
        check("exhaust again", 32'(credit_cnt), 32'd0);

        // simultaneous push and return at credit_cnt=1
        drive(1'b0, 1'b1, 1'b1, 4'b0100);
        step();
        check("refill to one", 32'(credit_cnt), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 4'b0100);
        check("push+ret ready", 32'(req_ready), 32'b0100);
        step();
        check("push+ret cnt", 32'(credit_cnt), 32'd1);
        check("push+ret valid", 32'(fifo_valid), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        check("further grant", 32'(req_ready), 32'b0100);
        step();
        check("further cnt", 32'(credit_cnt), 32'd0);

        // enable low for 10 cycles after a grant to requester 1
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 4'b0010);
        step();
        check("pre-disable last", 32'(last_grant_id), 32'd1);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b0, 4'b1111);
            check($sformatf("disabled ready %0d", k), 32'(req_ready), 32'd0);
            step();
            check($sformatf("disabled fv %0d", k), 32'(fifo_valid), 32'd0);
        end
        check("disabled last", 32'(last_grant_id), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 4'b1111);
        check("reenable grant", 32'(req_ready), 32'b0100);
        step();

        // reset mid-burst
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b1111);
            step();
        end
        check("burst credit_cnt", 32'(credit_cnt), 32'd2);
        check("burst fifo_valid", 32'(fifo_valid), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 4'b1111);
        check("ready in reset", 32'(req_ready), 32'd0);
        step();
        check("post-rst fifo_valid", 32'(fifo_valid), 32'd0);
        check("post-rst credit_cnt", 32'(credit_cnt), 32'd5);
        check("post-rst credit_err", 32'(credit_err), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 4'b0110);
        check("post-rst first grant", 32'(req_ready), 32'b0010);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
